// File: rtl/round_state_mux.sv
// round_state_mux
// Iterates an externally computed round function over a registered cipher state.
// A block is accepted in IDLE, gets exactly ROUNDS round updates in RUN, then waits in
// DONE until the consumer takes it.
//
// Ports:
//   clk        input            rising-edge clock
//   reset      input            asynchronous active-low reset
//   flush      input            synchronous abort back to IDLE (state value kept)
//   data_in    input  [DATA_W]  initial state for a new block
//   in_valid   input            data_in is valid
//   in_ready   output           high only in IDLE
//   round_in   input  [DATA_W]  round function applied to state_out
//   state_out  output [DATA_W]  registered state driving the round function
//   round_cnt  output [CNT_W]   index of the round currently being computed
//   data_out   output [DATA_W]  finished block (same register as state_out)
//   out_valid  output           high only in DONE
//   out_ready  input            consumer accepts data_out
module round_state_mux #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ROUNDS = 31,
   parameter int unsigned CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [DATA_W-1:0] data_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] round_in,
   output logic [DATA_W-1:0] state_out,
   output logic [CNT_W-1:0]  round_cnt,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [CNT_W-1:0] LastRound = CNT_W'(ROUNDS);

   typedef enum logic [1:0] {StIdle, StRun, StDone} st_e;

   st_e               st_q, st_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q   <= StIdle;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         st_q   <= st_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      if (flush) begin
         // Abort wins over load, round update and hand-off; the state value is kept.
         st_d  = StIdle;
         cnt_d = '0;
      end else begin
         unique case (st_q)
            StIdle: begin
               if (in_valid) begin
                  data_d = data_in;
                  cnt_d  = CNT_W'(1);
                  st_d   = StRun;
               end
            end
            StRun: begin
               data_d = round_in;
               // Counter saturates at the last round, so it never wraps.
               if (cnt_q == LastRound) begin
                  st_d = StDone;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StDone: begin
               if (out_ready) begin
                  st_d  = StIdle;
                  cnt_d = '0;
               end
            end
            default: begin
               st_d  = StIdle;
               cnt_d = '0;
            end
         endcase
      end
   end

   assign in_ready  = (st_q == StIdle);
   assign out_valid = (st_q == StDone);
   assign state_out = data_q;
   assign data_out  = data_q;
   assign round_cnt = cnt_q;

endmodule

// File: tb/tb_round_state_mux.sv
module tb_round_state_mux;

   localparam int unsigned RoundsA = 31;
   localparam int unsigned RoundsB = 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;

   logic [63:0] data_in_a = '0, round_in_a, state_out_a, data_out_a;
   logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0;
   logic [4:0]  round_cnt_a;

   logic [63:0] data_in_b = '0, round_in_b, state_out_b, data_out_b;
   logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0;
   logic [4:0]  round_cnt_b;

   assign round_in_a = state_out_a + 64'd1;
   assign round_in_b = state_out_b + 64'd1;

   round_state_mux #(.DATA_W(64), .ROUNDS(RoundsA), .CNT_W(5)) u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .data_in   (data_in_a),
      .in_valid  (in_valid_a),
      .in_ready  (in_ready_a),
      .round_in  (round_in_a),
      .state_out (state_out_a),
      .round_cnt (round_cnt_a),
      .data_out  (data_out_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a)
   );

   round_state_mux #(.DATA_W(64), .ROUNDS(RoundsB), .CNT_W(5)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .flush     (1'b0),
      .data_in   (data_in_b),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .round_in  (round_in_b),
      .state_out (state_out_b),
      .round_cnt (round_cnt_b),
      .data_out  (data_out_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   // Monitors: a rising out_valid must match the oldest expected block, both data and cycle.
   logic ov_a_prev = 1'b0;
   logic ov_b_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (out_valid_a && !ov_a_prev) begin
         if (q_a.size() == 0) begin
            check("unexpected_out_a", 64'(out_valid_a), 64'd0);
         end else begin
            e = q_a.pop_front();
            check("data_out_a", data_out_a, e.data);
            check("latency_a", 64'(cyc), 64'(e.cyc));
         end
      end
      if (out_valid_b && !ov_b_prev) begin
         if (q_b.size() == 0) begin
            check("unexpected_out_b", 64'(out_valid_b), 64'd0);
         end else begin
            e = q_b.pop_front();
            check("data_out_b", data_out_b, e.data);
            check("latency_b", 64'(cyc), 64'(e.cyc));
         end
      end
      ov_a_prev = out_valid_a;
      ov_b_prev = out_valid_b;
   end

   task automatic accept_a(input logic [63:0] d, input bit expect_out);
      exp_t e;
      @(posedge clk);
      #1;
      data_in_a  = d;
      in_valid_a = 1'b1;
      @(posedge clk);
      #1;
      in_valid_a = 1'b0;
      if (expect_out) begin
         e.data = d + 64'(RoundsA);
         e.cyc  = cyc + int'(RoundsA);
         q_a.push_back(e);
      end
   endtask

   task automatic wait_valid_a(input int bound);
      bit seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (out_valid_a) seen = 1'b1;
      end
      check("wait_out_valid_a", 64'(seen), 64'd1);
   endtask

   initial begin
      exp_t eb;
      bit   seen;

      // Reset state, before any clock edge
      #1;
      check("rst_in_ready", 64'(in_ready_a), 64'd1);
      check("rst_out_valid", 64'(out_valid_a), 64'd0);
      check("rst_state", state_out_a, 64'd0);
      check("rst_cnt", 64'(round_cnt_a), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Basic block: 0 -> 0x1F, then hold in DONE for 10 cycles
      accept_a(64'd0, 1'b1);
      check("run_in_ready", 64'(in_ready_a), 64'd0);
      check("run_cnt_start", 64'(round_cnt_a), 64'd1);
      wait_valid_a(40);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_data", data_out_a, 64'h1F);
         check("hold_in_ready", 64'(in_ready_a), 64'd0);
         check("hold_cnt", 64'(round_cnt_a), 64'd31);
         check("hold_valid", 64'(out_valid_a), 64'd1);
      end
      out_ready_a = 1'b1;
      @(posedge clk);
      #1;
      out_ready_a = 1'b0;
      check("release_in_ready", 64'(in_ready_a), 64'd1);
      check("release_cnt", 64'(round_cnt_a), 64'd0);
      check("release_valid", 64'(out_valid_a), 64'd0);

      // in_valid pulse during RUN is ignored
      accept_a(64'd0, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      data_in_a  = 64'hFFFF;
      in_valid_a = 1'b1;
      @(posedge clk);
      #1;
      in_valid_a = 1'b0;
      wait_valid_a(40);
      // Hand-off edge with in_valid high must not load a new block
      data_in_a   = 64'hAB;
      in_valid_a  = 1'b1;
      out_ready_a = 1'b1;
      @(posedge clk);
      #1;
      in_valid_a  = 1'b0;
      out_ready_a = 1'b0;
      check("handoff_in_ready", 64'(in_ready_a), 64'd1);
      check("handoff_state", state_out_a, 64'h1F);
      check("handoff_cnt", 64'(round_cnt_a), 64'd0);

      // Asynchronous reset at round_cnt == 12
      accept_a(64'h100, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (round_cnt_a == 5'd12) seen = 1'b1;
      end
      check("reach_cnt12", 64'(seen), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_state", state_out_a, 64'd0);
      check("async_valid", 64'(out_valid_a), 64'd0);
      check("async_in_ready", 64'(in_ready_a), 64'd1);
      check("async_cnt", 64'(round_cnt_a), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (35) @(negedge clk);
      check("abandoned_valid", 64'(out_valid_a), 64'd0);

      // flush with in_valid in IDLE: no load
      @(posedge clk);
      #1;
      flush      = 1'b1;
      in_valid_a = 1'b1;
      data_in_a  = 64'h55;
      @(posedge clk);
      #1;
      flush      = 1'b0;
      in_valid_a = 1'b0;
      check("flush_idle_in_ready", 64'(in_ready_a), 64'd1);
      check("flush_idle_state", state_out_a, 64'd0);
      check("flush_idle_cnt", 64'(round_cnt_a), 64'd0);

      // flush mid-RUN: back to IDLE, state value kept
      accept_a(64'h200, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_run_in_ready", 64'(in_ready_a), 64'd1);
      check("flush_run_state", state_out_a, 64'h203);
      check("flush_run_cnt", 64'(round_cnt_a), 64'd0);

      // flush together with out_ready in DONE
      accept_a(64'd7, 1'b1);
      wait_valid_a(40);
      flush       = 1'b1;
      out_ready_a = 1'b1;
      @(posedge clk);
      #1;
      flush       = 1'b0;
      out_ready_a = 1'b0;
      check("flush_done_in_ready", 64'(in_ready_a), 64'd1);
      check("flush_done_valid", 64'(out_valid_a), 64'd0);
      check("flush_done_state", state_out_a, 64'd38);
      check("flush_done_cnt", 64'(round_cnt_a), 64'd0);

      // ROUNDS = 1 instance
      @(posedge clk);
      #1;
      data_in_b  = 64'h0123456789ABCDEF;
      in_valid_b = 1'b1;
      @(posedge clk);
      #1;
      in_valid_b = 1'b0;
      eb.data = 64'h0123456789ABCDF0;
      eb.cyc  = cyc + int'(RoundsB);
      q_b.push_back(eb);
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         @(negedge clk);
         if (out_valid_b) seen = 1'b1;
      end
      check("wait_out_valid_b", 64'(seen), 64'd1);
      check("b_cnt", 64'(round_cnt_b), 64'd1);
      out_ready_b = 1'b1;
      @(posedge clk);
      #1;
      out_ready_b = 1'b0;
      check("b_release_in_ready", 64'(in_ready_b), 64'd1);

      repeat (2) @(negedge clk);
      check("q_a_empty", 64'(q_a.size()), 64'd0);
      check("q_b_empty", 64'(q_b.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/round_state_mux.md
ROUND_STATE_MUX -- requirements
Module: round_state_mux

Interface
REQ-001 Parameter DATA_W, default 64, width of the cipher state path.
REQ-002 Parameter ROUNDS, default 31, number of round updates per block; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 5, width of the round counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous abort; returns block to IDLE.
REQ-007 data_in  input  DATA_W  new plaintext/initial state.
REQ-008 in_valid  input  1  data_in is valid.
REQ-009 in_ready  output  1  block can accept data_in.
REQ-010 round_in  input  DATA_W  combinational result of the external round function applied to state_out.
REQ-011 state_out  output  DATA_W  current registered state, fed to the round function.
REQ-012 round_cnt  output  CNT_W  index of the round currently being computed.
REQ-013 data_out  output  DATA_W  finished block; equals state_out.
REQ-014 out_valid  output  1  data_out holds a finished block.
REQ-015 out_ready  input  1  consumer accepts data_out.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-018 In IDLE with in_valid=1 at an edge, the block SHALL load state<=data_in, set round_cnt<=1 and go to RUN.
REQ-019 In RUN, each edge SHALL load state<=round_in.
REQ-020 In RUN with round_cnt<ROUNDS, each edge SHALL increment round_cnt.
REQ-021 In RUN with round_cnt==ROUNDS, the edge SHALL go to DONE and hold round_cnt.
REQ-022 Each accepted block SHALL receive exactly ROUNDS round updates.
REQ-023 out_valid SHALL rise in the cycle following the ROUNDS-th edge after the accept edge (latency ROUNDS cycles).
REQ-024 out_valid SHALL be 1 only in DONE.
REQ-025 In DONE, state, data_out and round_cnt SHALL hold stable until out_ready=1.
REQ-026 In DONE, an edge with out_ready=1 SHALL go to IDLE and clear round_cnt to 0. A new block cannot be accepted in that same cycle.
REQ-027 in_valid SHALL be ignored in RUN and DONE, and round_in SHALL be ignored in IDLE and DONE.
REQ-028 flush=1 at an edge SHALL force IDLE and round_cnt=0, and leave state unchanged. flush has priority over every other transition, including load and out_ready.
REQ-029 round_cnt arithmetic is unsigned, CNT_W bits; it never wraps because it saturates at ROUNDS.
REQ-030 With ROUNDS=1, a block SHALL go IDLE->RUN->DONE with exactly one round update.

Reset
REQ-031 While reset=0, the block SHALL be in IDLE, with state=0, round_cnt=0, out_valid=0 and in_ready=1, independent of clk.
REQ-032 Reset asserted mid-RUN or mid-DONE SHALL abandon the block with no output produced.
REQ-033 Reset deassertion is synchronised externally; the first active edge after deassertion SHALL follow REQ-018.

Verification
REQ-034 Bench stub round_in=state_out+1, ROUNDS=31: accept data_in=0 -> out_valid rises 31 cycles later with data_out=0x1F.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> data_out stays 0x1F and in_ready stays 0; out_ready=1 -> IDLE next cycle with round_cnt=0.
REQ-036 Pulse in_valid with data_in=0xFFFF during RUN -> ignored; the result is unchanged relative to REQ-034.
REQ-037 Drop reset to 0 at round_cnt=12 -> state=0, out_valid=0 and in_ready=1 immediately, with no clock edge required.
REQ-038 Assert flush and in_valid in the same IDLE edge -> no load occurs; assert flush in DONE together with out_ready -> IDLE.
REQ-039 ROUNDS=1, data_in=0x0123456789ABCDEF -> out_valid 1 cycle after accept with data_out=0x0123456789ABCDF0.
